// File: rtl/sr_shift_sched_pkg.sv
// Shared types for the shift-chain scheduler: transmit FSM states, frame tag, width helper.
package sr_shift_sched_pkg;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    // Tag source field is sized for up to 256 requesters; users take the low bits.
    localparam int TAG_SRC_W = 8;

    typedef struct packed {
        logic                 start;
        logic [TAG_SRC_W-1:0] src;
    } tag_t;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr_tag_delay.sv
// DEPTH-stage falling-edge delay line for frame tags, cleared asynchronously.
module sr_tag_delay
    import sr_shift_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk_i,
    input  logic clr_n_i,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    always_ff @(negedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sr_shift_sched.sv
// Round-robin scheduler feeding one SISO shift chain and reassembling its output.
//   state    | meaning
//   TX_IDLE  | sd held low, waiting for any request
//   TX_SHIFT | frame bits driven on sd, MSB first; grant re-opens on the last bit
module sr_shift_sched
    import sr_shift_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*W-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       sd,
    output logic                       sr_reset,
    input  logic                       sr_q,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   tx_src,
    output logic                       rx_valid,
    output logic [W-1:0]               rx_data,
    output logic [$clog2(N_REQ)-1:0]   rx_src
);

    localparam int SRC_W = src_w(N_REQ);
    localparam int CNT_W = src_w(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     tx_sh_q, tx_sh_d;
    logic             sd_q, sd_d;
    logic [SRC_W-1:0] tx_src_q, tx_src_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic             load_q;

    logic             load;
    logic             win_found;
    logic [SRC_W-1:0] win_src;
    logic [SRC_W-1:0] cand;
    logic [W-1:0]     win_data;
    int               idx;

    always_comb begin
        win_found = 1'b0;
        win_src   = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = SRC_W'(idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_src   = cand;
            end
        end
    end

    assign win_data  = req_data[win_src*W +: W];
    assign load      = win_found && ((state_q == TX_IDLE) || (cnt_q == LAST));
    assign req_ready = load ? (N_REQ'(1) << win_src) : '0;

    // tx_sh_q holds the bits still to be sent, left-aligned; sd_q is the bit on the wire.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_sh_d  = tx_sh_q;
        sd_d     = sd_q;
        tx_src_d = tx_src_q;
        ptr_d    = ptr_q;
        if (load) begin
            state_d  = TX_SHIFT;
            cnt_d    = '0;
            sd_d     = win_data[W-1];
            tx_sh_d  = win_data << 1;
            tx_src_d = win_src;
            ptr_d    = (win_src == SRC_W'(N_REQ - 1)) ? '0 : win_src + 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    sd_d = 1'b0;
                end
                TX_SHIFT: begin
                    if (cnt_q == LAST) begin
                        state_d = TX_IDLE;
                        cnt_d   = '0;
                        sd_d    = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        sd_d    = tx_sh_q[W-1];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            tx_sh_q  <= '0;
            sd_q     <= 1'b0;
            tx_src_q <= '0;
            ptr_q    <= '0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_sh_q  <= tx_sh_d;
            sd_q     <= sd_d;
            tx_src_q <= tx_src_d;
            ptr_q    <= ptr_d;
            load_q   <= load;
        end
    end

    // Tag enters one edge after load, so it exits exactly as the MSB reaches sr_q.
    tag_t tag_in, tag_out;

    always_comb begin
        tag_in       = '0;
        tag_in.start = load_q;
        tag_in.src   = TAG_SRC_W'(tx_src_q);
    end

    sr_tag_delay #(.DEPTH(DEPTH)) u_tag_delay (
        .clk_i   (clk),
        .clr_n_i (reset_n),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    generate
        if (SRC_W < TAG_SRC_W) begin : g_tag_hi
            logic unused_tag_hi;
            assign unused_tag_hi = ^tag_out.src[TAG_SRC_W-1:SRC_W];
        end
    endgenerate

    logic             rx_active_q, rx_active_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [W-1:0]     rx_shift_q, rx_shift_d;
    logic [SRC_W-1:0] rx_cur_src_q, rx_cur_src_d;
    logic             rx_valid_q, rx_valid_d;
    logic [W-1:0]     rx_data_q, rx_data_d;
    logic [SRC_W-1:0] rx_src_q, rx_src_d;

    always_comb begin
        rx_active_d  = rx_active_q;
        rx_cnt_d     = rx_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_cur_src_d = rx_cur_src_q;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        rx_src_d     = rx_src_q;
        if (rx_active_q) begin
            rx_shift_d = {rx_shift_q[W-2:0], sr_q};
            if (rx_cnt_q == LAST) begin
                rx_active_d = 1'b0;
                rx_cnt_d    = '0;
                rx_valid_d  = 1'b1;
                rx_data_d   = rx_shift_d;
                rx_src_d    = rx_cur_src_q;
            end else begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
        end else if (tag_out.start) begin
            rx_active_d  = 1'b1;
            rx_cnt_d     = CNT_W'(1);
            rx_shift_d   = {rx_shift_q[W-2:0], sr_q};
            rx_cur_src_d = tag_out.src[SRC_W-1:0];
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_active_q  <= 1'b0;
            rx_cnt_q     <= '0;
            rx_shift_q   <= '0;
            rx_cur_src_q <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_src_q     <= '0;
        end else begin
            rx_active_q  <= rx_active_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_cur_src_q <= rx_cur_src_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_src_q     <= rx_src_d;
        end
    end

    assign sd       = sd_q;
    assign sr_reset = ~reset_n;
    assign busy     = (state_q == TX_SHIFT);
    assign tx_src   = tx_src_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_src   = rx_src_q;

endmodule

// File: tb/tb_sr_shift_sched.sv
// Directed bench for sr_shift_sched with a behavioural 8-stage SISO chain on sd/sr_q.
module tb_sr_shift_sched;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        sd;
    logic        sr_reset;
    logic        sr_q;
    logic        busy;
    logic [1:0]  tx_src;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  rx_src;

    logic [7:0]  chain;
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;

    logic [1:0]  g_src[$];
    int          g_edge[$];
    logic [7:0]  r_data[$];
    logic [1:0]  r_src[$];
    int          r_edge[$];

    sr_shift_sched #(.N_REQ(4), .W(8), .DEPTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sd        (sd),
        .sr_reset  (sr_reset),
        .sr_q      (sr_q),
        .busy      (busy),
        .tx_src    (tx_src),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_src    (rx_src)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    always @(negedge clk or posedge sr_reset) begin
        if (sr_reset) chain <= 8'h00;
        else          chain <= {chain[6:0], sd};
    end
    assign sr_q = chain[7];

    always @(negedge clk) edge_n <= edge_n + 1;

    // Mid-cycle monitor: grants are tagged with the edge that will accept them.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (req_ready[k]) begin
                g_src.push_back(2'(k));
                g_edge.push_back(edge_n + 1);
            end
        end
        if (rx_valid) begin
            r_data.push_back(rx_data);
            r_src.push_back(rx_src);
            r_edge.push_back(edge_n);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        g_src.delete();
        g_edge.delete();
        r_data.delete();
        r_src.delete();
        r_edge.delete();
    endtask

    task automatic do_reset();
        step();
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        step();
        step();
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_rx(input int n, input int max_steps, output bit ok);
        for (int i = 0; i < max_steps && r_data.size() < n; i++) step();
        ok = (r_data.size() >= n);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        step();
        step();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
        checks++; if (sd !== 1'b0)       begin errors++; $display("FAIL rst_sd got %b exp 0", sd); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (tx_src !== 2'd0)   begin errors++; $display("FAIL rst_tx_src got %0d exp 0", tx_src); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
        checks++; if (rx_src !== 2'd0)   begin errors++; $display("FAIL rst_rx_src got %0d exp 0", rx_src); end
        checks++; if (sr_reset !== 1'b1) begin errors++; $display("FAIL rst_sr_reset got %b exp 1", sr_reset); end
        reset_n = 1'b1;
        #1;
        checks++; if (sr_reset !== 1'b0) begin errors++; $display("FAIL rel_sr_reset got %b exp 0", sr_reset); end
        clear_logs();
    endtask

    task automatic test_single();
        logic [7:0] pat;
        int         acc;
        bit         ok;
        pat = 8'hA5;
        step();
        req_data[7:0] = pat;
        req_valid     = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        acc = edge_n + 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                req_valid = 4'b0000;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0 got %b exp 1", busy); end
            end
            checks++; if (sd !== pat[7-i]) begin errors++; $display("FAIL single_sd_bit%0d got %b exp %b", i, sd, pat[7-i]); end
        end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_e8 got %b exp 0", busy); end
        checks++; if (sd !== 1'b0)   begin errors++; $display("FAIL single_sd_idle got %b exp 0", sd); end
        wait_rx(1, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_rx_timeout got %0d frames exp 1", r_data.size()); end
        if (ok) begin
            checks++; if (r_edge[0] - acc !== 16) begin errors++; $display("FAIL single_rx_latency got %0d exp 16", r_edge[0] - acc); end
            checks++; if (r_data[0] !== pat)      begin errors++; $display("FAIL single_rx_data got %h exp %h", r_data[0], pat); end
            checks++; if (r_src[0] !== 2'd0)      begin errors++; $display("FAIL single_rx_src got %0d exp 0", r_src[0]); end
        end
        for (int i = 0; i < 10; i++) step();
        checks++; if (r_data.size() !== 1) begin errors++; $display("FAIL single_rx_count got %0d exp 1", r_data.size()); end
    endtask

    task automatic test_contention();
        int seen;
        bit ok;
        do_reset();
        step();
        req_data[7:0]   = 8'h3C;
        req_data[23:16] = 8'hC3;
        req_valid       = 4'b0101;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            while (seen < g_src.size()) begin
                req_valid[g_src[seen]] = 1'b0;
                seen++;
            end
        end
        checks++; if (g_src.size() !== 2) begin errors++; $display("FAIL cont_grant_count got %0d exp 2", g_src.size()); end
        if (g_src.size() == 2) begin
            checks++; if (g_src[0] !== 2'd0) begin errors++; $display("FAIL cont_grant0 got %0d exp 0", g_src[0]); end
            checks++; if (g_src[1] !== 2'd2) begin errors++; $display("FAIL cont_grant1 got %0d exp 2", g_src[1]); end
            checks++; if (g_edge[1] - g_edge[0] !== 8) begin errors++; $display("FAIL cont_grant_gap got %0d exp 8", g_edge[1] - g_edge[0]); end
        end
        wait_rx(2, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_rx_timeout got %0d frames exp 2", r_data.size()); end
        if (ok && g_edge.size() >= 1) begin
            checks++; if (r_data[0] !== 8'h3C) begin errors++; $display("FAIL cont_rx0_data got %h exp 3c", r_data[0]); end
            checks++; if (r_src[0] !== 2'd0)   begin errors++; $display("FAIL cont_rx0_src got %0d exp 0", r_src[0]); end
            checks++; if (r_data[1] !== 8'hC3) begin errors++; $display("FAIL cont_rx1_data got %h exp c3", r_data[1]); end
            checks++; if (r_src[1] !== 2'd2)   begin errors++; $display("FAIL cont_rx1_src got %0d exp 2", r_src[1]); end
            checks++; if (r_edge[1] - r_edge[0] !== 8)  begin errors++; $display("FAIL cont_rx_gap got %0d exp 8", r_edge[1] - r_edge[0]); end
            checks++; if (r_edge[0] - g_edge[0] !== 16) begin errors++; $display("FAIL cont_rx_latency got %0d exp 16", r_edge[0] - g_edge[0]); end
        end
    endtask

    task automatic test_fairness();
        int drops;
        bit ok;
        do_reset();
        step();
        req_data[7:0]  = 8'h11;
        req_data[15:8] = 8'h22;
        req_valid      = 4'b0011;
        drops = 0;
        for (int i = 0; i < 80 && g_src.size() < 6; i++) begin
            step();
            if (g_src.size() >= 1 && busy !== 1'b1) drops++;
        end
        req_valid = 4'b0000;
        checks++; if (drops !== 0) begin errors++; $display("FAIL fair_busy_drops got %0d exp 0", drops); end
        checks++; if (g_src.size() !== 6) begin errors++; $display("FAIL fair_grant_count got %0d exp 6", g_src.size()); end
        if (g_src.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (g_src[k] !== 2'(k % 2)) begin errors++; $display("FAIL fair_grant%0d got %0d exp %0d", k, g_src[k], k % 2); end
            end
            checks++; if (g_edge[5] - g_edge[0] !== 40) begin errors++; $display("FAIL fair_span got %0d exp 40", g_edge[5] - g_edge[0]); end
        end
        wait_rx(6, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fair_rx_timeout got %0d frames exp 6", r_data.size()); end
        if (ok) begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (r_data[k] !== ((k % 2 == 0) ? 8'h11 : 8'h22)) begin errors++; $display("FAIL fair_rx%0d_data got %h", k, r_data[k]); end
            end
        end
    endtask

    task automatic test_withdrawn();
        int n3_g;
        int n3_r;
        do_reset();
        step();
        req_data[7:0]   = 8'h5A;
        req_data[31:24] = 8'h99;
        req_valid       = 4'b1001;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0) req_valid[0] = 1'b0;
            if (i == 3) req_valid[3] = 1'b0;
        end
        n3_g = 0;
        n3_r = 0;
        foreach (g_src[k]) if (g_src[k] == 2'd3) n3_g++;
        foreach (r_src[k]) if (r_src[k] == 2'd3) n3_r++;
        checks++; if (n3_g !== 0) begin errors++; $display("FAIL wd_grant3 got %0d exp 0", n3_g); end
        checks++; if (n3_r !== 0) begin errors++; $display("FAIL wd_rx3 got %0d exp 0", n3_r); end
        checks++; if (r_data.size() !== 1) begin errors++; $display("FAIL wd_rx_count got %0d exp 1", r_data.size()); end
        if (r_data.size() == 1) begin
            checks++; if (r_data[0] !== 8'h5A) begin errors++; $display("FAIL wd_rx_data got %h exp 5a", r_data[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit ok;
        clear_logs();
        step();
        req_data[15:8] = 8'hFF;
        req_valid      = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) req_valid = 4'b0000;
        end
        checks++; if (sd !== 1'b1)     begin errors++; $display("FAIL mid_sd_pre got %b exp 1", sd); end
        checks++; if (tx_src !== 2'd1) begin errors++; $display("FAIL mid_tx_src_pre got %0d exp 1", tx_src); end
        reset_n = 1'b0;
        #1;
        checks++; if (sd !== 1'b0)       begin errors++; $display("FAIL mid_sd got %b exp 0", sd); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (tx_src !== 2'd0)   begin errors++; $display("FAIL mid_tx_src got %0d exp 0", tx_src); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rx_data got %h exp 00", rx_data); end
        checks++; if (rx_src !== 2'd0)   begin errors++; $display("FAIL mid_rx_src got %0d exp 0", rx_src); end
        checks++; if (sr_reset !== 1'b1) begin errors++; $display("FAIL mid_sr_reset got %b exp 1", sr_reset); end
        clear_logs();
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        checks++; if (r_data.size() !== 0) begin errors++; $display("FAIL mid_no_rx got %0d frames exp 0", r_data.size()); end
        req_data[7:0]   = 8'h81;
        req_data[23:16] = 8'h7E;
        req_valid       = 4'b0101;
        acc = edge_n + 1;
        step();
        req_valid = 4'b0000;
        wait_rx(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_rx_timeout got %0d frames exp 1", r_data.size()); end
        if (ok) begin
            checks++; if (g_src[0] !== 2'd0)      begin errors++; $display("FAIL mid_grant got %0d exp 0", g_src[0]); end
            checks++; if (r_edge[0] - acc !== 16) begin errors++; $display("FAIL mid_rx_latency got %0d exp 16", r_edge[0] - acc); end
            checks++; if (r_data[0] !== 8'h81)    begin errors++; $display("FAIL mid_rx_data got %h exp 81", r_data[0]); end
            checks++; if (r_src[0] !== 2'd0)      begin errors++; $display("FAIL mid_rx_src got %0d exp 0", r_src[0]); end
        end
    endtask

    task automatic test_back_to_back();
        bit swapped;
        bit ok;
        do_reset();
        step();
        req_data[23:16] = 8'h00;
        req_valid       = 4'b0100;
        swapped = 1'b0;
        for (int i = 0; i < 20 && g_src.size() < 2; i++) begin
            step();
            if (g_src.size() == 1 && !swapped) begin
                req_data[23:16] = 8'hFF;
                swapped = 1'b1;
            end
        end
        req_valid = 4'b0000;
        checks++; if (g_src.size() !== 2) begin errors++; $display("FAIL b2b_grant_count got %0d exp 2", g_src.size()); end
        wait_rx(2, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_rx_timeout got %0d frames exp 2", r_data.size()); end
        if (ok && g_src.size() == 2) begin
            checks++; if (g_edge[1] - g_edge[0] !== 8) begin errors++; $display("FAIL b2b_grant_gap got %0d exp 8", g_edge[1] - g_edge[0]); end
            checks++; if (r_data[0] !== 8'h00) begin errors++; $display("FAIL b2b_rx0_data got %h exp 00", r_data[0]); end
            checks++; if (r_data[1] !== 8'hFF) begin errors++; $display("FAIL b2b_rx1_data got %h exp ff", r_data[1]); end
            checks++; if (r_src[0] !== 2'd2 || r_src[1] !== 2'd2) begin errors++; $display("FAIL b2b_rx_src got %0d,%0d exp 2,2", r_src[0], r_src[1]); end
            checks++; if (r_edge[1] - r_edge[0] !== 8) begin errors++; $display("FAIL b2b_rx_gap got %0d exp 8", r_edge[1] - r_edge[0]); end
        end
        for (int i = 0; i < 5; i++) step();
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_rx_hold got %h exp ff", rx_data); end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_withdrawn();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_shift_sched.md
# sr_shift_sched

Round-robin scheduler that shares one 8-stage SISO shift chain (`SR_SISO`) between `N_REQ` byte requesters. It accepts a byte from one requester at a time and drives it serially, MSB first, into the chain's `d` input. It also reassembles each byte as it emerges at the chain's `q` output and reports it with the originating requester ID. The block sits between the requester ports and the shift-chain instance and is the only driver of that chain.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, ≥2.
- `W`, default 8: data width, equal to bits per frame.
- `DEPTH`, default 8: number of shift-chain stages. It must match the chain instance.

Ports:
- `clk`, in, 1: clock. All state changes on the falling edge, the same edge as the shift chain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `N_REQ`: per-requester request.
- `req_data`, in, `N_REQ*W`: requester i occupies bits `[i*W +: W]`.
- `req_ready`, out, `N_REQ`: one-hot grant. It is combinational and is high during the cycle whose closing edge captures the data.
- `sd`, out, 1: serial data to the chain `d` input. Registered.
- `sr_reset`, out, 1: `~reset_n`, for the chain's active-high reset.
- `sr_q`, in, 1: chain `q` output.
- `busy`, out, 1: a frame is being shifted in.
- `tx_src`, out, `$clog2(N_REQ)`: requester currently shifting.
- `rx_valid`, out, 1: one-cycle pulse when a frame has been reassembled.
- `rx_data`, out, `W`: reassembled byte. Held until the next `rx_valid`.
- `rx_src`, out, `$clog2(N_REQ)`: requester ID of `rx_data`.

## Operation
- Transmit FSM has two states, IDLE and SHIFT.
  - In IDLE, `sd`=0. When any `req_valid` is high, the round-robin winner gets `req_ready`. At the edge, the byte is loaded into the tx shift register, the bit counter is set to 0, and the FSM moves to SHIFT.
  - In SHIFT, `sd` = tx_reg[W-1-cnt]. `cnt` increments on each edge.
  - In the last bit cycle (`cnt`=W-1), a new grant is allowed. If one is issued, the next frame loads with no gap. Otherwise the FSM returns to IDLE.
- Round robin:
  - The pointer holds the highest-priority requester and starts at 0 after reset.
  - After a grant to requester k, the pointer becomes (k+1) mod `N_REQ`.
  - A requester may deassert `req_valid` before it is granted. Data must be stable while `req_valid` is high.
- Frame tag:
  - Each load pushes a tag {start=1, src} into a `DEPTH`-entry delay line. The delay line advances every edge.
  - The tag reaches the delay-line output exactly when the frame's MSB appears on `sr_q`.
- Receive:
  - On a tag start, the receiver captures `sr_q` for W consecutive edges, MSB first, into `rx_shift`.
  - After the W-th capture, the receiver registers `rx_data`/`rx_src` and pulses `rx_valid`.
  - A new tag arriving on the W-th capture edge starts the next frame without a gap.
- Reset, asynchronous or mid-frame:
  - FSM goes to IDLE, counters to 0, pointer to 0, delay line cleared.
  - `sd`, `busy`, `tx_src`, `rx_valid`, `rx_data`, `rx_src` all go to 0.
  - Frames in flight are dropped and produce no `rx_valid`.

## Timing
- Acceptance edge is E0. MSB is on `sd` from E0 to E1. Bit W-1-i is on `sd` from Ei to Ei+1.
- The chain samples bit i at Ei+1. That bit is on `sr_q` after E(i+DEPTH).
- The receiver captures at E(DEPTH+1) through E(DEPTH+W). `rx_valid` is high in the cycle after E(DEPTH+W), which is 16 edges after acceptance with the defaults.
- Sustained throughput is one frame per W cycles.
- `busy` is high from E0 to EW, and continuously across back-to-back frames.

## Structure
- The shared package holds:
  - The FSM state enum (IDLE, SHIFT).
  - The tag struct {start, src}.
  - The `SRC_W = $clog2(N_REQ)` helper.
- One sub-module, `sr_tag_delay`: a parameterised `DEPTH`-stage delay line for tags with asynchronous active-low clear.
- Round-robin grant logic stays inline.

## Test plan
- **Single byte:** requester 0 sends 0xA5.
  - `sd` = 1,0,1,0,0,1,0,1 on consecutive cycles.
  - `rx_valid` 16 edges after acceptance, with `rx_data`=0xA5 and `rx_src`=0.
- **Contention:** after reset, requesters 0 and 2 are both valid with 0x3C and 0xC3.
  - Grant 0 first, then grant 2 at the last-bit edge with no gap.
  - rx frames in the same order, 8 cycles apart.
- **Fairness:** requesters 0 and 1 valid continuously for 6 frames.
  - Grants alternate 0,1,0,1,0,1.
  - `busy` never drops.
- **Withdrawn request:** requester 3 drops `req_valid` before it is granted.
  - No grant to requester 3.
  - No rx frame from src 3.
- **Reset mid-frame:** assert `reset_n`=0 at bit 4 of 0xFF.
  - All outputs 0 immediately.
  - No `rx_valid` afterwards.
  - The next request after release gets a clean 16-edge frame.
- **Back-to-back boundary data:** 0x00 then 0xFF from one requester.
  - `rx_data` is exactly 0x00 then 0xFF.
  - No bit bleeds from one frame into the other.
